// File: rtl/if_id_latch.sv
// IF/ID pipeline register: latches fetched instruction and PC+4, splits decode fields,
// detects HALT (sticky) and counts loaded valid non-HALT instructions. Latency 1 cycle.
module if_id_latch #(
    parameter int                   NB_DATA     = 32,
    parameter int                   NB_IMM      = 16,
    parameter int                   NB_OPCODE   = 6,
    parameter logic [NB_OPCODE-1:0] HALT_OPCODE = 6'h3F,
    parameter int                   NB_CNT      = 16
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_enable,
    input  logic               i_stall,
    input  logic               i_flush,
    input  logic               i_valid,
    input  logic [NB_DATA-1:0] i_instruction,
    input  logic [NB_DATA-1:0] i_pc_plus4,
    output logic               o_valid,
    output logic [NB_DATA-1:0] o_instruction,
    output logic [NB_DATA-1:0] o_pc_plus4,
    output logic [5:0]         o_opcode,
    output logic [4:0]         o_rs,
    output logic [4:0]         o_rt,
    output logic [4:0]         o_rd,
    output logic [4:0]         o_shamt,
    output logic [5:0]         o_funct,
    output logic [NB_IMM-1:0]  o_immediate,
    output logic [25:0]        o_jump_target,
    output logic               o_halt,
    output logic [NB_CNT-1:0]  o_inst_count
);

    logic               valid_q;
    logic [NB_DATA-1:0] instr_q;
    logic [NB_DATA-1:0] pc_q;
    logic               halt_q;
    logic [NB_CNT-1:0]  cnt_q;
    logic               in_is_halt;

    assign in_is_halt = (i_instruction[NB_DATA-1 -: NB_OPCODE] == HALT_OPCODE);

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            valid_q <= 1'b0;
            instr_q <= '0;
            pc_q    <= '0;
            halt_q  <= 1'b0;
            cnt_q   <= '0;
        end else if (i_enable && !halt_q) begin
            // Flush outranks stall: a taken branch must squash even a stalled slot.
            if (i_flush) begin
                valid_q <= 1'b0;
                instr_q <= '0;
                pc_q    <= '0;
            end else if (!i_stall) begin
                valid_q <= i_valid;
                instr_q <= i_valid ? i_instruction : '0;
                pc_q    <= i_pc_plus4;
                if (i_valid && in_is_halt) begin
                    halt_q <= 1'b1;
                end else if (i_valid && (cnt_q != {NB_CNT{1'b1}})) begin
                    cnt_q <= cnt_q + 1'b1;
                end
            end
        end
    end

    assign o_valid       = valid_q;
    assign o_instruction = instr_q;
    assign o_pc_plus4    = pc_q;
    assign o_halt        = halt_q;
    assign o_inst_count  = cnt_q;

    assign o_opcode      = instr_q[31:26];
    assign o_rs          = instr_q[25:21];
    assign o_rt          = instr_q[20:16];
    assign o_rd          = instr_q[15:11];
    assign o_shamt       = instr_q[10:6];
    assign o_funct       = instr_q[5:0];
    assign o_immediate   = instr_q[NB_IMM-1:0];
    assign o_jump_target = instr_q[25:0];

endmodule

// File: tb/tb_if_id_latch.sv
// Directed bench for if_id_latch; small counter width so saturation is reachable quickly.
module tb_if_id_latch;

    localparam int NB_CNT = 4;

    logic        clk = 1'b0;
    logic        reset, enable, stall, flush, valid;
    logic [31:0] instruction, pc_plus4;
    logic        o_valid, o_halt;
    logic [31:0] o_instruction, o_pc_plus4;
    logic [5:0]  o_opcode, o_funct;
    logic [4:0]  o_rs, o_rt, o_rd, o_shamt;
    logic [15:0] o_immediate;
    logic [25:0] o_jump_target;
    logic [NB_CNT-1:0] o_inst_count;

    int checks   = 0;
    int failures = 0;

    if_id_latch #(.NB_CNT(NB_CNT)) dut (
        .i_clk(clk), .i_reset(reset), .i_enable(enable), .i_stall(stall),
        .i_flush(flush), .i_valid(valid), .i_instruction(instruction),
        .i_pc_plus4(pc_plus4), .o_valid(o_valid), .o_instruction(o_instruction),
        .o_pc_plus4(o_pc_plus4), .o_opcode(o_opcode), .o_rs(o_rs), .o_rt(o_rt),
        .o_rd(o_rd), .o_shamt(o_shamt), .o_funct(o_funct),
        .o_immediate(o_immediate), .o_jump_target(o_jump_target),
        .o_halt(o_halt), .o_inst_count(o_inst_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Advance one edge; inputs change and outputs are sampled 1 time unit after it.
    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        reset = 1'b0; enable = 1'b1; stall = 1'b0; flush = 1'b0;
        valid = 1'b1; instruction = 32'h2022_0005; pc_plus4 = 32'h8;

        // T1 reset wins over a valid input
        step(2);
        check("rst_valid", o_valid, 0);
        check("rst_instr", o_instruction, 0);
        check("rst_pc", o_pc_plus4, 0);
        check("rst_halt", o_halt, 0);
        check("rst_cnt", o_inst_count, 0);
        check("rst_opcode", o_opcode, 0);

        // T2 addi load and field split
        reset = 1'b1; instruction = 32'h2022_FFFF; pc_plus4 = 32'h4;
        step(1);
        check("t2_opcode", o_opcode, 6'h08);
        check("t2_rs", o_rs, 5'd1);
        check("t2_rt", o_rt, 5'd2);
        check("t2_rd", o_rd, 5'd31);
        check("t2_shamt", o_shamt, 5'd31);
        check("t2_funct", o_funct, 6'h3F);
        check("t2_imm", o_immediate, 16'hFFFF);
        check("t2_jt", o_jump_target, 26'h022_FFFF);
        check("t2_valid", o_valid, 1);
        check("t2_pc", o_pc_plus4, 32'h4);
        check("t2_cnt", o_inst_count, 1);

        // T3 stall holds, then flush beats stall
        stall = 1'b1; instruction = 32'h0000_7000; pc_plus4 = 32'h8;
        step(3);
        check("t3_stall_instr", o_instruction, 32'h2022_FFFF);
        check("t3_stall_pc", o_pc_plus4, 32'h4);
        check("t3_stall_cnt", o_inst_count, 1);
        flush = 1'b1;
        step(1);
        check("t3_flush_instr", o_instruction, 0);
        check("t3_flush_valid", o_valid, 0);
        check("t3_flush_pc", o_pc_plus4, 0);
        check("t3_flush_cnt", o_inst_count, 1);
        flush = 1'b0; stall = 1'b0;

        // T4 enable low freezes, then loads
        enable = 1'b0; instruction = 32'h2000_8000; pc_plus4 = 32'hC;
        step(1);
        check("t4_frozen_instr", o_instruction, 0);
        check("t4_frozen_valid", o_valid, 0);
        enable = 1'b1;
        step(1);
        check("t4_imm", o_immediate, 16'h8000);
        check("t4_rt", o_rt, 0);
        check("t4_cnt", o_inst_count, 2);

        // Bubble: invalid input loads zero instruction, PC still captured
        valid = 1'b0; instruction = 32'h1234_5678; pc_plus4 = 32'h10;
        step(1);
        check("bub_instr", o_instruction, 0);
        check("bub_valid", o_valid, 0);
        check("bub_pc", o_pc_plus4, 32'h10);
        check("bub_cnt", o_inst_count, 2);

        // T5 HALT latched, count unchanged, then frozen
        valid = 1'b1; instruction = 32'hFC00_0000; pc_plus4 = 32'h14;
        step(1);
        check("t5_halt", o_halt, 1);
        check("t5_valid", o_valid, 1);
        check("t5_instr", o_instruction, 32'hFC00_0000);
        check("t5_cnt", o_inst_count, 2);
        instruction = 32'h2022_0005; pc_plus4 = 32'h18;
        step(1);
        check("t5_hold_instr", o_instruction, 32'hFC00_0000);
        check("t5_hold_cnt", o_inst_count, 2);
        flush = 1'b1;
        step(1);
        check("t5_flush_ignored", o_valid, 1);
        check("t5_halt_sticky", o_halt, 1);
        flush = 1'b0;

        // Reset clears halt even with enable low
        reset = 1'b0; enable = 1'b0;
        step(1);
        check("rst2_halt", o_halt, 0);
        check("rst2_cnt", o_inst_count, 0);
        check("rst2_instr", o_instruction, 0);
        reset = 1'b1; enable = 1'b1;

        // T6 HALT arriving with flush is squashed
        instruction = 32'hFC00_0000; flush = 1'b1;
        step(1);
        check("t6_halt", o_halt, 0);
        check("t6_valid", o_valid, 0);
        check("t6_cnt", o_inst_count, 0);
        flush = 1'b0;

        // Counter saturation at all-ones
        instruction = 32'h2022_0001;
        step(14);
        check("sat_14", o_inst_count, 14);
        step(1);
        check("sat_15", o_inst_count, 15);
        step(5);
        check("sat_hold", o_inst_count, 15);
        check("sat_valid", o_valid, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
